// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the round-robin arbiter and one consumer.
// The arbiter sits on the slave modport; the producer/consumer side uses the master modport.
interface rr_arb_mux_if #(
   parameter int DATA_BITS = 8,
   parameter int NUM_CH    = 4,
   parameter int SEL_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0]           in_valid;
   logic [NUM_CH*DATA_BITS-1:0] in_data;
   logic [NUM_CH-1:0]           in_mask;
   logic [NUM_CH-1:0]           in_ready;
   logic                        out_valid;
   logic [DATA_BITS-1:0]        out_data;
   logic [SEL_BITS-1:0]         out_sel;
   logic                        out_ready;

   modport master (
      output in_valid, in_data, in_mask, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, in_mask, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N:1 mux with round-robin arbitration, per-channel masking and a single
// output pipeline stage that can drain and refill in the same cycle.
module rr_arb_mux #(
   parameter int DATA_BITS = 8,
   parameter int NUM_CH    = 4
) (
   input logic          clk,
   input logic          reset_n,
   rr_arb_mux_if.slave  bus
);
   localparam int SEL_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SUM_BITS = SEL_BITS + 1;
   localparam logic [SEL_BITS-1:0] LAST_CH = SEL_BITS'(NUM_CH - 1);

   logic [NUM_CH-1:0]    eligible;
   logic [NUM_CH-1:0]    grant;
   logic [SEL_BITS-1:0]  grant_sel;
   logic                 any_grant;
   logic [SUM_BITS-1:0]  cand;
   logic [DATA_BITS-1:0] sel_data;
   logic                 load;

   logic [SEL_BITS-1:0]  last_grant;
   logic                 valid_q;
   logic [DATA_BITS-1:0] data_q;
   logic [SEL_BITS-1:0]  sel_q;

   assign eligible = bus.in_valid & bus.in_mask;
   assign load     = ~valid_q | bus.out_ready;

   // Scan from last_grant+1 with wrap; sum stays below 2*NUM_CH so one subtract suffices.
   always_comb begin
      grant     = '0;
      grant_sel = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = {1'b0, last_grant} + SUM_BITS'(k + 1);
         if (cand >= SUM_BITS'(NUM_CH)) begin
            cand = cand - SUM_BITS'(NUM_CH);
         end
         if (!any_grant && eligible[cand[SEL_BITS-1:0]]) begin
            any_grant                  = 1'b1;
            grant_sel                  = cand[SEL_BITS-1:0];
            grant[cand[SEL_BITS-1:0]]  = 1'b1;
         end
      end
   end

   // AND-OR select keeps X on ungranted channels away from the output register.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_data = sel_data | bus.in_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         sel_q      <= '0;
         last_grant <= LAST_CH;
      end else if (load) begin
         if (any_grant) begin
            valid_q    <= 1'b1;
            data_q     <= sel_data;
            sel_q      <= grant_sel;
            last_grant <= grant_sel;
         end else begin
            valid_q    <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = reset_n ? (grant & {NUM_CH{load}}) : '0;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios followed by random traffic, all checked
// against a queue-free behavioural model of round-robin selection and the output register.
module tb_rr_arb_mux;
   localparam int DATA_BITS = 8;
   localparam int NUM_CH    = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rr_arb_mux_if #(.DATA_BITS(DATA_BITS), .NUM_CH(NUM_CH)) bus ();

   rr_arb_mux #(.DATA_BITS(DATA_BITS), .NUM_CH(NUM_CH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [NUM_CH-1:0]    cur_v;
   logic [NUM_CH-1:0]    cur_m;
   logic                 cur_r;
   logic [DATA_BITS-1:0] d [NUM_CH];

   // Reference state: what the output register should hold and who was served last.
   bit                   m_valid;
   logic [DATA_BITS-1:0] m_data;
   int                   m_sel;
   int                   ptr;

   int sat_sel  [6] = '{0, 1, 2, 3, 0, 1};
   int sat_data [6] = '{'h10, 'h21, 'h32, 'h43, 'h10, 'h21};
   int sparse_sel [3] = '{0, 1, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      ptr     = NUM_CH - 1;
   endfunction

   function automatic int model_pick();
      for (int off = 1; off <= NUM_CH; off++) begin
         int c;
         c = (ptr + off) % NUM_CH;
         if (cur_v[c] && cur_m[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NUM_CH-1:0] model_ready();
      int g;
      if (!reset_n) return '0;
      if (m_valid && !cur_r) return '0;
      g = model_pick();
      if (g < 0) return '0;
      return NUM_CH'(1) << g;
   endfunction

   task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] m, input logic r);
      cur_v = v;
      cur_m = m;
      cur_r = r;
      bus.in_valid  = v;
      bus.in_mask   = m;
      bus.out_ready = r;
      for (int i = 0; i < NUM_CH; i++) bus.in_data[i*DATA_BITS +: DATA_BITS] = d[i];
   endtask

   // One clock: check in_ready before the edge, advance the model, check the register after.
   task automatic cycle();
      int g;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("onehot0", 32'($onehot0(bus.in_ready)), 32'd1);
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else if (!m_valid || cur_r) begin
         g = model_pick();
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g];
            m_sel   = g;
            ptr     = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
   endtask

   initial begin
      logic [NUM_CH-1:0] rv;
      logic [NUM_CH-1:0] rm;
      logic              rr;

      d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'h32; d[3] = 8'h43;
      model_reset();
      drive(4'b0000, 4'b1111, 1'b1);

      // Reset held for three cycles, then with requests pending
      repeat (3) begin
         cycle();
         chk("rst_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_data", 32'(bus.out_data), 32'h00);
         chk("rst_ready", 32'(bus.in_ready), 32'd0);
      end
      drive(4'b1111, 4'b1111, 1'b1);
      cycle();
      chk("rst_ready_req", 32'(bus.in_ready), 32'd0);
      chk("rst_valid_req", 32'(bus.out_valid), 32'd0);

      // Saturation rotation
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("sat_sel", 32'(bus.out_sel), 32'(sat_sel[i]));
         chk("sat_data", 32'(bus.out_data), 32'(sat_data[i]));
         chk("sat_valid", 32'(bus.out_valid), 32'd1);
      end

      // Async reset in the middle of the stream
      cycle();
      #3 reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_valid", 32'(bus.out_valid), 32'd0);
      chk("async_data", 32'(bus.out_data), 32'h00);
      cycle();
      reset_n = 1'b1;
      cycle();
      chk("post_rst_sel", 32'(bus.out_sel), 32'd0);
      chk("post_rst_data", 32'(bus.out_data), 32'h10);

      // Backpressure holding ch0, then same-cycle drain/refill with ch2
      drive(4'b0101, 4'b1111, 1'b0);
      repeat (3) begin
         cycle();
         chk("bp_data", 32'(bus.out_data), 32'h10);
         chk("bp_sel", 32'(bus.out_sel), 32'd0);
         chk("bp_ready", 32'(bus.in_ready), 32'd0);
      end
      drive(4'b0101, 4'b1111, 1'b1);
      #1;
      chk("bp_resume_ready", 32'(bus.in_ready), 32'b0100);
      cycle();
      chk("bp_resume_data", 32'(bus.out_data), 32'h32);
      chk("bp_resume_valid", 32'(bus.out_valid), 32'd1);

      // Sparse rotation from last_grant=2
      drive(4'b0011, 4'b1111, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("sparse_sel", 32'(bus.out_sel), 32'(sparse_sel[i]));
      end

      // Masking: the only requester is masked, then unmasked
      drive(4'b0000, 4'b1111, 1'b1);
      cycle();
      drive(4'b1000, 4'b0111, 1'b1);
      repeat (2) begin
         cycle();
         chk("mask_ready", 32'(bus.in_ready), 32'd0);
         chk("mask_valid", 32'(bus.out_valid), 32'd0);
      end
      drive(4'b1000, 4'b1111, 1'b1);
      #1;
      chk("unmask_ready", 32'(bus.in_ready), 32'b1000);
      cycle();
      chk("unmask_data", 32'(bus.out_data), 32'h43);
      chk("unmask_sel", 32'(bus.out_sel), 32'd3);

      // Random traffic; data of non-eligible channels is driven as X
      repeat (400) begin
         rv = NUM_CH'($urandom);
         for (int i = 0; i < NUM_CH; i++) rm[i] = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < NUM_CH; i++) begin
            if (rv[i] && rm[i]) d[i] = DATA_BITS'($urandom);
            else                d[i] = 'x;
         end
         drive(rv, rm, rr);
         cycle();
         if ($urandom_range(0, 49) == 0) begin
            #2 reset_n = 1'b0;
            model_reset();
            #1;
            chk("rand_async_valid", 32'(bus.out_valid), 32'd0);
            #1 reset_n = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered N-to-1 multiplexer with per-channel valid/ready handshakes and round-robin arbitration.
- Parametrised successor to the fixed-width 2:1 and 8:1 register muxers.
- Sits between multiple producers (ALU result, load unit, immediate path) and a single register-file write port or shared bus.
- Adds one output pipeline stage, backpressure handling, per-channel masking and fair grant rotation.

Parameters:
- DATA_BITS, 8, width of each data channel.
- NUM_CH, 4, number of input channels (1..16).
- SEL_BITS, derived: max(1, $clog2(NUM_CH)), width of the grant index.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel request; bit i is channel i.
- in_data  input  NUM_CH*DATA_BITS  packed channel data; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- in_mask  input  NUM_CH  per-channel enable; 0 excludes the channel from arbitration.
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_BITS  registered selected data.
- out_sel  output  SEL_BITS  index of the channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous on reset_n low):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has top priority after reset.
  - in_ready=0 while reset_n is low.
- Eligibility: eligible[i] = in_valid[i] & in_mask[i].
- Load condition: load = ~out_valid | out_ready.
- Grant (combinational): search starts at last_grant+1 modulo NUM_CH, wraps around, and picks the first eligible channel. grant is one-hot or zero.
- in_ready[i] = grant[i] & load. A transfer occurs on channel i when in_valid[i] & in_ready[i].
- Rising clk, load=1 with a grant at channel g:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1; last_grant <= g.
- Rising clk, load=1 with no eligible channel: out_valid <= 0; out_data, out_sel and last_grant hold.
- Rising clk, load=0 (out_valid=1, out_ready=0): all registers hold and in_ready=0 for all channels.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready stays high. Simultaneous drain and refill in the same cycle is required; no bubble is allowed.
- Fairness: with all channels continuously eligible, grants rotate 0,1,...,NUM_CH-1,0,...
  - A channel that deasserts is skipped.
  - The pointer advances only on an actual transfer.
- Mask: a masked channel never receives in_ready, even if it is the only valid channel. Changing in_mask takes effect in the same cycle (combinational).
- NUM_CH=1: grant = eligible[0]; out_sel is constantly 0; the pointer logic degenerates to a constant.
- Data of non-granted channels is don't-care. X or Z on an ungranted or masked channel must not propagate to out_data.
- Reset mid-transfer: the held word is discarded and out_valid drops immediately (asynchronously). No transfer is counted in the reset cycle.
- Assertions for verification:
  - $onehot0(in_ready).
  - out_valid & ~out_ready implies out_data and out_sel are stable in the next cycle.
  - The producer must hold in_data stable while in_valid=1 and in_ready=0.

Test Plan:
- Reset then idle (NUM_CH=4, DATA_BITS=8): reset_n low 3 cycles, all in_valid=0 -> out_valid=0, out_data=0x00, in_ready=4'b0000 throughout.
- Round-robin saturation:
  - Stimulus: in_valid=4'b1111, in_mask=4'b1111, data ch0..ch3 = 0x10,0x21,0x32,0x43, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0,1; out_data 0x10,0x21,0x32,0x43,0x10,0x21; out_valid continuously 1 from cycle 1.
- Backpressure:
  - Stimulus: in_valid=4'b0101 and out_ready=0 after the first capture (ch0, 0x10), held 3 cycles.
  - Required: out_data stays 0x10, out_sel=0, in_ready=0000 for those cycles. On out_ready=1, the next word is ch2 in the same cycle, with no bubble.
- Masking: in_valid=4'b1000, in_mask=4'b0111 -> in_ready=0000, out_valid stays 0. Unmasking ch3 -> in_ready=4'b1000, and out_data=0x43 one cycle later.
- Sparse rotation: last_grant=2, in_valid=4'b0011 -> grant ch0 (wrap-around), then ch1, then ch0.
- Async reset mid-stream: during saturation, reset_n pulses low mid-cycle -> out_valid=0 before the next clk edge. After release, the first grant is ch0.
